// File: rtl/pnu_regbank_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Holds the FSM state enum, default sizes and a clog2 helper.
package pnu_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_EXEC,
      ST_DONE
   } state_t;

   localparam int DEF_N_REQ = 3;
   localparam int DEF_W     = 4;
   localparam int DEF_N_REG = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pnu_regbank_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports: req (request levels), ptr (highest-priority index),
// win (one-hot winner), win_idx (winner index).
module pnu_rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [PW-1:0] win_idx
);

   logic found;

   // Scan priorities ptr, ptr+1, ... (wrapping); first hit wins.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] &&
                (j == (int'(ptr) + k) % N)) begin
               found   = 1'b1;
               win[j]  = 1'b1;
               win_idx = PW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/pnu_regbank_arbiter.sv
// Round-robin arbiter/sequencer sharing a bank of CE registers.
// Ports: CLK, RST (async high); req/we/addr/wdata per requester;
// gnt (one-hot), ack (done pulse), rdata (last read result);
// reg_ce/reg_din drive the bank, reg_dout reads it back.
module pnu_regbank_arbiter
   import pnu_regbank_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int W     = DEF_W,
   parameter int N_REG = DEF_N_REG,
   parameter int AW    = clog2(N_REG)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   we,
   input  logic [N_REQ*AW-1:0] addr,
   input  logic [N_REQ*W-1:0] wdata,
   output logic [N_REQ-1:0]   gnt,
   output logic               ack,
   output logic [W-1:0]       rdata,
   output logic [N_REG-1:0]   reg_ce,
   output logic [W-1:0]       reg_din,
   input  logic [N_REG*W-1:0] reg_dout
);

   localparam int PW = clog2(N_REQ);

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               ack_q, ack_d;
   logic [W-1:0]       rdata_q, rdata_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      widx_q, widx_d;
   logic               we_q, we_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [W-1:0]       wdata_q, wdata_d;

   logic [N_REQ-1:0]   win;
   logic [PW-1:0]      win_idx;
   logic               req_sel;
   logic               we_sel;
   logic [AW-1:0]      addr_sel;
   logic [W-1:0]       wdata_sel;
   logic [W-1:0]       dout_sel;

   pnu_rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win     (win),
      .win_idx (win_idx)
   );

   // Per-winner input slices and bank read mux.
   always_comb begin
      req_sel   = 1'b0;
      we_sel    = 1'b0;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (widx_q == PW'(i)) begin
            req_sel   = req[i];
            we_sel    = we[i];
            addr_sel  = addr[i*AW +: AW];
            wdata_sel = wdata[i*W +: W];
         end
      end
      dout_sel = '0;
      for (int j = 0; j < N_REG; j++) begin
         if (addr_q == AW'(j)) begin
            dout_sel = reg_dout[j*W +: W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      ptr_d   = ptr_q;
      widx_d  = widx_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d   = win;
               widx_d  = win_idx;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            we_d    = we_sel;
            addr_d  = addr_sel;
            wdata_d = wdata_sel;
            // Winner withdrew: abort without touching ptr.
            if (req_sel) begin
               state_d = ST_EXEC;
            end else begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (!we_q) begin
               rdata_d = dout_sel;
            end
            ack_d   = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            ack_d   = 1'b0;
            gnt_d   = '0;
            ptr_d   = (widx_q == PW'(N_REQ - 1)) ?
                      '0 : widx_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         ptr_q   <= '0;
         widx_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         ptr_q   <= ptr_d;
         widx_q  <= widx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Decoded from flops only, so reset cuts a pulse at once.
   always_comb begin
      reg_ce = '0;
      if (state_q == ST_EXEC && we_q) begin
         for (int j = 0; j < N_REG; j++) begin
            if (addr_q == AW'(j)) begin
               reg_ce[j] = 1'b1;
            end
         end
      end
   end

   assign reg_din = wdata_q;
   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign rdata   = rdata_q;

endmodule
